// File: rtl/mips_wb_trace.sv
// Writeback tracer for the mips core: stamps each register writeback, queues it in a
// first-word-fall-through FIFO, mirrors it into a shadow regfile and flags program end.
module mips_wb_trace #(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic               CK,
    input  logic               RESET,
    input  logic               IN_VALID,
    input  logic [4:0]         IN_ADDR,
    input  logic [31:0]        IN_DATA,
    input  logic               IN_DONE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [STAMP_W-1:0] OUT_STAMP,
    output logic [4:0]         OUT_ADDR,
    output logic [31:0]        OUT_DATA,
    input  logic [4:0]         SHADOW_RADDR,
    output logic [31:0]        SHADOW_RDATA,
    output logic [LVL_W-1:0]   LEVEL,
    output logic [7:0]         DROP_CNT,
    output logic               FINISHED
);

    logic [STAMP_W-1:0] stamp;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [7:0]         drop_cnt;
    logic               done_latch;

    logic [STAMP_W-1:0] mem_stamp [DEPTH];
    logic [4:0]         mem_addr  [DEPTH];
    logic [31:0]        mem_data  [DEPTH];
    logic [31:0]        shadow    [32];

    logic push_req;
    logic full;
    logic pop;
    logic push_ok;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Once DONE is latched the core's stream is ignored entirely.
    assign push_req = IN_VALID && !done_latch;
    assign full     = (level == LVL_W'(DEPTH));
    assign pop      = OUT_VALID && OUT_READY;
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge CK or negedge RESET) begin
        if (!RESET) begin
            stamp      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_cnt   <= '0;
            done_latch <= 1'b0;
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else begin
            stamp      <= stamp + 1'b1;
            done_latch <= done_latch | IN_DONE;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (!push_ok && pop) level <= level - 1'b1;
            if (push_req && !push_ok) drop_cnt <= sat_inc8(drop_cnt);
            // Register 0 is hardwired; its writes are traced but never stored.
            if (push_req && (IN_ADDR != 5'd0)) shadow[IN_ADDR] <= IN_DATA;
        end
    end

    // Payload storage carries no reset; empty-FIFO outputs are masked below.
    always_ff @(posedge CK) begin
        if (push_ok) begin
            mem_stamp[wr_ptr] <= stamp;
            mem_addr[wr_ptr]  <= IN_ADDR;
            mem_data[wr_ptr]  <= IN_DATA;
        end
    end

    assign OUT_VALID    = (level != '0);
    assign OUT_STAMP    = OUT_VALID ? mem_stamp[rd_ptr] : '0;
    assign OUT_ADDR     = OUT_VALID ? mem_addr[rd_ptr]  : '0;
    assign OUT_DATA     = OUT_VALID ? mem_data[rd_ptr]  : '0;
    assign SHADOW_RDATA = shadow[SHADOW_RADDR];
    assign LEVEL        = level;
    assign DROP_CNT     = drop_cnt;
    assign FINISHED     = done_latch && (level == '0);

endmodule

// File: tb/tb_mips_wb_trace.sv
// Bench for mips_wb_trace: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mips_wb_trace;

    localparam int DEPTH = 16;

    logic        CK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [4:0]  IN_ADDR = '0;
    logic [31:0] IN_DATA = '0;
    logic        IN_DONE = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_STAMP;
    logic [4:0]  OUT_ADDR;
    logic [31:0] OUT_DATA;
    logic [4:0]  SHADOW_RADDR = '0;
    logic [31:0] SHADOW_RDATA;
    logic [4:0]  LEVEL;
    logic [7:0]  DROP_CNT;
    logic        FINISHED;

    mips_wb_trace #(.DEPTH(DEPTH), .STAMP_W(16)) dut (
        .CK(CK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA),
        .IN_DONE(IN_DONE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_STAMP(OUT_STAMP),
        .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA), .SHADOW_RADDR(SHADOW_RADDR),
        .SHADOW_RDATA(SHADOW_RDATA), .LEVEL(LEVEL), .DROP_CNT(DROP_CNT), .FINISHED(FINISHED)
    );

    always #50 CK = ~CK;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of traced entries plus counters.
    typedef struct {
        logic [15:0] s;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          m_stamp = 0;
    int          m_drop = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_shadow [32];

    always @(posedge CK or negedge RESET) begin
        if (!RESET) begin
            q.delete();
            m_stamp = 0;
            m_drop = 0;
            m_done = 1'b0;
            for (int i = 0; i < 32; i++) m_shadow[i] = '0;
        end else begin
            int n;
            bit pop;
            bit preq;
            n = q.size();
            pop = (n > 0) && OUT_READY;
            preq = IN_VALID && !m_done;
            if (pop) q.delete(0);
            if (preq) begin
                if (n < DEPTH || pop) q.push_back('{s: 16'(m_stamp), a: IN_ADDR, d: IN_DATA});
                else if (m_drop < 255) m_drop++;
                if (IN_ADDR != 0) m_shadow[IN_ADDR] = IN_DATA;
            end
            if (IN_DONE) m_done = 1'b1;
            m_stamp = (m_stamp + 1) % 65536;
        end
    end

    always @(negedge CK) begin
        if (started) begin
            check("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_stamp", 32'(OUT_STAMP), 32'(q[0].s));
                check("out_addr", 32'(OUT_ADDR), 32'(q[0].a));
                check("out_data", OUT_DATA, q[0].d);
            end else begin
                check("out_stamp_empty", 32'(OUT_STAMP), 32'd0);
                check("out_data_empty", OUT_DATA, 32'd0);
            end
            check("level", 32'(LEVEL), 32'(q.size()));
            check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
            check("finished", 32'(FINISHED), 32'(m_done && q.size() == 0));
            check("shadow_rdata", SHADOW_RDATA, m_shadow[SHADOW_RADDR]);
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_in();
        IN_VALID = 1'b0;
        IN_DONE  = 1'b0;
    endtask

    logic [31:0] dq_data[$];
    logic [15:0] dq_stamp[$];

    task automatic drain();
        dq_data.delete();
        dq_stamp.delete();
        OUT_READY = 1'b1;
        for (int k = 0; k < 100 && OUT_VALID; k++) begin
            dq_data.push_back(OUT_DATA);
            dq_stamp.push_back(OUT_STAMP);
            step();
        end
        check("drain_empty", 32'(OUT_VALID), 32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        @(posedge CK);
        #5;
        RESET = 1'b0;
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_drop", 32'(DROP_CNT), 32'd0);
        check("rst_finished", 32'(FINISHED), 32'd0);
        check("rst_out_data", OUT_DATA, 32'd0);
        for (int i = 0; i < 32; i++) begin
            SHADOW_RADDR = 5'(i);
            #1;
            check("rst_shadow", SHADOW_RDATA, 32'd0);
        end
        RESET = 1'b1;
    endtask

    initial begin
        #1 RESET = 1'b0;
        repeat (3) step();
        started = 1'b1;
        RESET = 1'b1;

        // Single write at stamp 5
        repeat (5) step();
        IN_VALID = 1'b1; IN_ADDR = 5'd8; IN_DATA = 32'h2A; OUT_READY = 1'b1;
        step();
        idle_in();
        check("single_valid", 32'(OUT_VALID), 32'd1);
        check("single_stamp", 32'(OUT_STAMP), 32'h5);
        check("single_addr", 32'(OUT_ADDR), 32'h8);
        check("single_data", OUT_DATA, 32'h2A);
        SHADOW_RADDR = 5'd8;
        step();
        check("single_shadow", SHADOW_RDATA, 32'h2A);
        check("single_popped", 32'(LEVEL), 32'd0);

        // Overflow: 20 writes with the consumer stalled
        OUT_READY = 1'b0;
        SHADOW_RADDR = 5'd3;
        for (int i = 0; i < 20; i++) begin
            IN_VALID = 1'b1; IN_ADDR = 5'd3; IN_DATA = 32'(i);
            step();
        end
        idle_in();
        check("ovf_level", 32'(LEVEL), 32'd16);
        check("ovf_drop", 32'(DROP_CNT), 32'd4);
        check("ovf_shadow", SHADOW_RDATA, 32'h13);
        check("ovf_head", OUT_DATA, 32'd0);

        // Full with simultaneous push and pop
        IN_VALID = 1'b1; IN_ADDR = 5'd4; IN_DATA = 32'hABC; OUT_READY = 1'b1;
        step();
        idle_in();
        OUT_READY = 1'b0;
        check("fullpp_level", 32'(LEVEL), 32'd16);
        check("fullpp_drop", 32'(DROP_CNT), 32'd4);
        drain();
        check("fullpp_count", 32'(dq_data.size()), 32'd16);
        if (dq_data.size() == 16) begin
            check("fullpp_first", dq_data[0], 32'd1);
            check("fullpp_15th", dq_data[14], 32'd15);
            check("fullpp_last", dq_data[15], 32'hABC);
            for (int i = 1; i < 15; i++)
                check("ovf_stamp_consec", 32'(dq_stamp[i] - dq_stamp[i-1]), 32'd1);
        end

        // Register 0 write
        IN_VALID = 1'b1; IN_ADDR = 5'd0; IN_DATA = 32'hFFFF_FFFF; OUT_READY = 1'b1;
        SHADOW_RADDR = 5'd0;
        step();
        idle_in();
        check("r0_addr", 32'(OUT_ADDR), 32'd0);
        check("r0_data", OUT_DATA, 32'hFFFF_FFFF);
        check("r0_shadow", SHADOW_RDATA, 32'd0);
        step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            IN_VALID     = ($urandom_range(0, 3) != 0);
            IN_ADDR      = 5'($urandom_range(0, 31));
            IN_DATA      = $urandom;
            OUT_READY    = ($urandom_range(0, 2) == 0);
            SHADOW_RADDR = 5'($urandom_range(0, 31));
            step();
        end
        idle_in();

        // Reset in the middle of operation
        pulse_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 18; i++) begin
            IN_VALID = 1'b1; IN_ADDR = 5'(i + 1); IN_DATA = 32'h100 + 32'(i);
            step();
        end
        idle_in();
        OUT_READY = 1'b1;
        repeat (11) step();
        OUT_READY = 1'b0;
        check("mid_level", 32'(LEVEL), 32'd5);
        check("mid_drop", 32'(DROP_CNT), 32'd2);
        pulse_reset();
        IN_VALID = 1'b1; IN_ADDR = 5'd7; IN_DATA = 32'h77;
        step();
        idle_in();
        check("restart_stamp", 32'(OUT_STAMP), 32'd0);
        check("restart_level", 32'(LEVEL), 32'd1);

        // DONE handling
        OUT_READY = 1'b0;
        SHADOW_RADDR = 5'd5;
        IN_VALID = 1'b1; IN_ADDR = 5'd5; IN_DATA = 32'h55; IN_DONE = 1'b1;
        step();
        IN_DONE = 1'b0; IN_DATA = 32'h66;
        step();
        idle_in();
        check("done_level", 32'(LEVEL), 32'd2);
        check("done_shadow", SHADOW_RDATA, 32'h55);
        check("done_not_finished", 32'(FINISHED), 32'd0);
        drain();
        check("done_drained", 32'(dq_data.size()), 32'd2);
        if (dq_data.size() == 2) check("done_last", dq_data[1], 32'h55);
        check("finished", 32'(FINISHED), 32'd1);
        IN_VALID = 1'b1; IN_ADDR = 5'd5; IN_DATA = 32'h99;
        repeat (4) step();
        idle_in();
        check("finished_sticky", 32'(FINISHED), 32'd1);
        check("done_shadow_frozen", SHADOW_RDATA, 32'h55);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
